if_fetch_queue: RTL and testbench

//  Instruction-fetch front end: the requester side of the instruction ROM port.

---
 rtl/if_fetch_queue_if.sv | 26 ++
 rtl/if_fetch_queue.sv | 138 +++++++++++++
 tb/tb_if_fetch_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: instruction ROM port, decode handshake and redirect controls.
// master = fetch queue side, slave = ROM / decode / control side.
interface if_fetch_queue_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst, id_adel,
    input  rom_inst, id_ready, branch_flag, branch_target, flush, new_pc
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst, id_adel,
    output rom_inst, id_ready, branch_flag, branch_target, flush, new_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: drives the ROM port, queues {pc, inst} and feeds decode.
// Optional IF_ALIGN_CHECK_EN: misaligned pc pushes an address-error entry and halts fetch.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  if_fetch_queue_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

`ifdef IF_ALIGN_CHECK_EN
  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;
`else
  typedef enum logic {StIdle, StRun} state_e;
`endif

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
`ifdef IF_ALIGN_CHECK_EN
  logic        adel_mem_q [DEPTH];
`endif

  logic head_valid, pop, full, run, branch_taken, trim, push, pc_aligned;

  always_comb begin
    head_valid   = (count_q != '0);
    pop          = head_valid & bus.id_ready;
    full         = (count_q == FullCnt);
    run          = (state_q == StRun);
    branch_taken = bus.branch_flag & pop & ~bus.flush;
    // Branch with a queued delay slot: keep that slot only, drop this cycle's fetch.
    trim         = branch_taken & (count_q > CntW'(1));
    push         = run & (~full | pop) & ~bus.flush & ~trim;
`ifdef IF_ALIGN_CHECK_EN
    pc_aligned   = (pc_q[1:0] == 2'b00);
`else
    pc_aligned   = 1'b1;
`endif
  end

  assign bus.rom_ce   = push & pc_aligned;
  assign bus.rom_addr = pc_q;
  assign bus.id_valid = head_valid;
  assign bus.id_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign bus.id_inst  = head_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
`ifdef IF_ALIGN_CHECK_EN
  assign bus.id_adel  = head_valid & adel_mem_q[rd_ptr_q];
`else
  assign bus.id_adel  = 1'b0;
`endif

  function automatic logic [31:0] redirect_pc(input logic [31:0] target);
`ifdef IF_ALIGN_CHECK_EN
    return target;
`else
    return {target[31:2], 2'b00};
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    case (state_q)
      StIdle:  state_d = StRun;
      StRun: begin
`ifdef IF_ALIGN_CHECK_EN
        if (push && !pc_aligned) state_d = StHalt;
`endif
      end
      default: state_d = state_q;
    endcase

    if (bus.flush) begin
      state_d  = StRun;
      pc_d     = redirect_pc(bus.new_pc);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (trim) begin
      pc_d     = redirect_pc(bus.branch_target);
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      wr_ptr_d = rd_ptr_q + PtrW'(2);
      count_d  = CntW'(1);
    end else begin
      if (branch_taken) begin
        pc_d = redirect_pc(bus.branch_target);
      end else if (push && pc_aligned) begin
        pc_d = pc_q + 32'd4;
      end
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      count_d  = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= pc_aligned ? bus.rom_inst : 32'h0;
`ifdef IF_ALIGN_CHECK_EN
      adel_mem_q[wr_ptr_q] <= ~pc_aligned;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=2, RESET_PC=0).
// Covers reset, latency, backpressure, branch delay slot, flush priority and alignment.
module tb_if_fetch_queue;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  if_fetch_queue_if bus ();

  if_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.rom_inst = bus.rom_ce ? rom_word(bus.rom_addr) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.branch_flag   = 1'b0;
    bus.branch_target = 32'h0;
    bus.flush         = 1'b0;
    bus.new_pc        = 32'h0;
  endtask

  // Ends at a falling edge with reset released: the DUT is in its idle cycle.
  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    clear_inputs();
    bus.id_ready = ready;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (bus.rom_ce !== 1'b0) $display("FAIL rst_rom_ce got %h want 0", bus.rom_ce); else pass_cnt++;
    total_cnt++; if (bus.id_valid !== 1'b0) $display("FAIL rst_id_valid got %h want 0", bus.id_valid); else pass_cnt++;
    total_cnt++; if (bus.id_pc !== 32'h0) $display("FAIL rst_id_pc got %h want 0", bus.id_pc); else pass_cnt++;
    total_cnt++; if (bus.id_inst !== 32'h0) $display("FAIL rst_id_inst got %h want 0", bus.id_inst); else pass_cnt++;
    total_cnt++; if (bus.id_adel !== 1'b0) $display("FAIL rst_id_adel got %h want 0", bus.id_adel); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (bus.rom_ce !== 1'b0) $display("FAIL cyc0_rom_ce got %h want 0", bus.rom_ce); else pass_cnt++;
    total_cnt++; if (bus.rom_addr !== 32'h0) $display("FAIL cyc0_rom_addr got %h want 0", bus.rom_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.rom_ce !== 1'b1) $display("FAIL cyc1_rom_ce got %h want 1", bus.rom_ce); else pass_cnt++;
    total_cnt++; if (bus.id_valid !== 1'b0) $display("FAIL cyc1_id_valid got %h want 0", bus.id_valid); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.id_valid !== 1'b1) $display("FAIL cyc2_id_valid got %h want 1", bus.id_valid); else pass_cnt++;
    total_cnt++; if (bus.id_pc !== 32'h0) $display("FAIL cyc2_id_pc got %h want 0", bus.id_pc); else pass_cnt++;
    total_cnt++; if (bus.id_inst !== 32'hC0DE_0000) $display("FAIL cyc2_id_inst got %h want c0de0000", bus.id_inst); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.id_pc !== 32'h4) $display("FAIL cyc3_id_pc got %h want 4", bus.id_pc); else pass_cnt++;
    total_cnt++; if (bus.id_inst !== 32'hC0DE_0004) $display("FAIL cyc3_id_inst got %h want c0de0004", bus.id_inst); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      total_cnt++; if (bus.rom_ce !== 1'b0) $display("FAIL bp_rom_ce[%0d] got %h want 0", i, bus.rom_ce); else pass_cnt++;
      total_cnt++; if (bus.rom_addr !== 32'h8) $display("FAIL bp_rom_addr[%0d] got %h want 8", i, bus.rom_addr); else pass_cnt++;
      total_cnt++; if (bus.id_pc !== 32'h0) $display("FAIL bp_head[%0d] got %h want 0", i, bus.id_pc); else pass_cnt++;
    end
    cyc();
    bus.id_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * i))
        $display("FAIL bp_drain[%0d] got valid %h pc %h want valid 1 pc %h", i, bus.id_valid, bus.id_pc, 32'(4 * i));
      else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_branch_deep();
    do_reset(1'b1);
    cyc();
    cyc();
    bus.id_ready = 1'b0;
    bus.flush    = 1'b1;
    bus.new_pc   = 32'h10;
    #1;
    total_cnt++; if (bus.rom_ce !== 1'b0) $display("FAIL flush_rom_ce got %h want 0", bus.rom_ce); else pass_cnt++;
    cyc();
    clear_inputs();
    #1;
    total_cnt++; if (bus.rom_addr !== 32'h10 || bus.id_valid !== 1'b0) $display("FAIL deep_refill got addr %h valid %h want addr 10 valid 0", bus.rom_addr, bus.id_valid); else pass_cnt++;
    cyc();
    cyc();
    total_cnt++; if (bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h18) $display("FAIL deep_full got ce %h addr %h want ce 0 addr 18", bus.rom_ce, bus.rom_addr); else pass_cnt++;
    bus.id_ready      = 1'b1;
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h100;
    #1;
    total_cnt++; if (bus.id_pc !== 32'h10 || bus.rom_ce !== 1'b0) $display("FAIL deep_branch got pc %h ce %h want pc 10 ce 0", bus.id_pc, bus.rom_ce); else pass_cnt++;
    cyc();
    clear_inputs();
    #1;
    total_cnt++; if (bus.id_pc !== 32'h14) $display("FAIL deep_slot got %h want 14", bus.id_pc); else pass_cnt++;
    total_cnt++; if (bus.rom_addr !== 32'h100 || bus.rom_ce !== 1'b1) $display("FAIL deep_target got addr %h ce %h want addr 100 ce 1", bus.rom_addr, bus.rom_ce); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.id_pc !== 32'h100) $display("FAIL deep_after got %h want 100", bus.id_pc); else pass_cnt++;
  endtask

  // Branch whose delay slot is fetched in the same cycle as the branch pops.
  task automatic test_branch_empty(input logic [31:0] target);
    do_reset(1'b1);
    cyc();
    cyc();
    bus.flush  = 1'b1;
    bus.new_pc = 32'h10;
    cyc();
    clear_inputs();
    cyc();
    bus.branch_flag   = 1'b1;
    bus.branch_target = target;
    #1;
    total_cnt++; if (bus.id_pc !== 32'h10 || bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h14) $display("FAIL empty_branch got pc %h ce %h addr %h want pc 10 ce 1 addr 14", bus.id_pc, bus.rom_ce, bus.rom_addr); else pass_cnt++;
    cyc();
    clear_inputs();
    #1;
    total_cnt++; if (bus.id_pc !== 32'h14 || bus.id_inst !== 32'hC0DE_0014) $display("FAIL empty_slot got pc %h inst %h want pc 14 inst c0de0014", bus.id_pc, bus.id_inst); else pass_cnt++;
  endtask

  task automatic test_branch_target_plain();
    test_branch_empty(32'h100);
    total_cnt++; if (bus.rom_addr !== 32'h100) $display("FAIL empty_target got %h want 100", bus.rom_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.id_pc !== 32'h100) $display("FAIL empty_after got %h want 100", bus.id_pc); else pass_cnt++;
  endtask

  task automatic test_align();
    test_branch_empty(32'h102);
`ifdef IF_ALIGN_CHECK_EN
    total_cnt++; if (bus.rom_addr !== 32'h102 || bus.rom_ce !== 1'b0) $display("FAIL align_fetch got addr %h ce %h want addr 102 ce 0", bus.rom_addr, bus.rom_ce); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.id_pc !== 32'h102 || bus.id_inst !== 32'h0 || bus.id_adel !== 1'b1) $display("FAIL align_head got pc %h inst %h adel %h want pc 102 inst 0 adel 1", bus.id_pc, bus.id_inst, bus.id_adel); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total_cnt++; if (bus.rom_ce !== 1'b0 || bus.id_valid !== 1'b0) $display("FAIL align_halt[%0d] got ce %h valid %h want 0 0", i, bus.rom_ce, bus.id_valid); else pass_cnt++;
    end
    bus.flush  = 1'b1;
    bus.new_pc = 32'h40;
    cyc();
    clear_inputs();
    #1;
    total_cnt++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h40) $display("FAIL align_resume got ce %h addr %h want ce 1 addr 40", bus.rom_ce, bus.rom_addr); else pass_cnt++;
`else
    total_cnt++; if (bus.rom_addr !== 32'h100 || bus.rom_ce !== 1'b1) $display("FAIL align_fetch got addr %h ce %h want addr 100 ce 1", bus.rom_addr, bus.rom_ce); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.id_pc !== 32'h100 || bus.id_adel !== 1'b0) $display("FAIL align_head got pc %h adel %h want pc 100 adel 0", bus.id_pc, bus.id_adel); else pass_cnt++;
`endif
  endtask

  task automatic test_flush_branch();
    do_reset(1'b1);
    cyc();
    cyc();
    bus.flush         = 1'b1;
    bus.new_pc        = 32'h180;
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h200;
    #1;
    total_cnt++; if (bus.id_valid !== 1'b1 || bus.rom_ce !== 1'b0) $display("FAIL fb_cycle got valid %h ce %h want valid 1 ce 0", bus.id_valid, bus.rom_ce); else pass_cnt++;
    cyc();
    clear_inputs();
    #1;
    total_cnt++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h180 || bus.rom_ce !== 1'b1) $display("FAIL fb_next got valid %h addr %h ce %h want 0 180 1", bus.id_valid, bus.rom_addr, bus.rom_ce); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.id_pc !== 32'h180) $display("FAIL fb_head got %h want 180", bus.id_pc); else pass_cnt++;
  endtask

  task automatic test_reset_pulse();
    cyc();
    total_cnt++; if (bus.id_valid !== 1'b1) $display("FAIL pulse_pre got valid %h want 1", bus.id_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.rom_ce !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 || bus.rom_addr !== 32'h0 || bus.id_adel !== 1'b0)
      $display("FAIL pulse_reset got ce %h valid %h pc %h inst %h addr %h adel %h want all 0", bus.rom_ce, bus.id_valid, bus.id_pc, bus.id_inst, bus.rom_addr, bus.id_adel);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    bus.id_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_backpressure();
    test_branch_deep();
    test_branch_target_plain();
    test_flush_branch();
    test_reset_pulse();
    test_align();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
